triangle_scene_ctrl: RTL and testbench

TRIANGLE_SCENE_CTRL -- requirements
Module: triangle_scene_ctrl

---
 rtl/triangle_scene_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_triangle_scene_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_scene_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// triangle_scene_ctrl: preset triangle loader with frame-synchronous commit.
// Optional bounce animation built only when TRI_SCENE_ANIM_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
module triangle_scene_ctrl #(
  parameter int X_MIN    = 285,
  parameter int X_MAX    = 1554,
  parameter int Y_MIN    = 35,
  parameter int Y_MAX    = 514,
  parameter int ANIM_DIV = 4
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        btn_next,
  output logic [10:0] p1_x,
  output logic [10:0] p2_x,
  output logic [10:0] p3_x,
  output logic [9:0]  p1_y,
  output logic [9:0]  p2_y,
  output logic [9:0]  p3_y,
  output logic [1:0]  preset_idx,
  output logic        busy
);

  // Each preset packs {x1,y1,x2,y2,x3,y3}, 11 bits per field, x1 in the MSBs.
  localparam logic [65:0] PRESET [4] = '{
    {11'd300,  11'd100, 11'd400,  11'd300, 11'd600,  11'd200},
    {11'd700,  11'd50,  11'd500,  11'd400, 11'd900,  11'd400},
    {11'd400,  11'd200, 11'd800,  11'd100, 11'd1200, 11'd450},
    {11'd1000, 11'd60,  11'd1400, 11'd60,  11'd1200, 11'd480}
  };

`ifdef TRI_SCENE_ANIM_EN
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, MOVE = 3'd2, PEND = 3'd3, COMMIT = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, PEND = 3'd3, COMMIT = 3'd4} state_t;
`endif

  state_t      state, state_nx;
  logic        btn_q;
  logic        btn_edge;
  logic        req;
  logic        start_load;
  logic [2:0]  load_cnt;
  logic [10:0] load_val;
  logic [10:0] sh_x  [3];
  logic [9:0]  sh_y  [3];
  logic [10:0] out_x [3];
  logic [9:0]  out_y [3];

  assign btn_edge   = btn_next & ~btn_q;
  assign start_load = (state == IDLE) && (btn_edge || req);
  assign busy       = (state != IDLE);
  assign load_val   = PRESET[preset_idx][int'(3'd5 - load_cnt) * 11 +: 11];

  assign p1_x = out_x[0];
  assign p2_x = out_x[1];
  assign p3_x = out_x[2];
  assign p1_y = out_y[0];
  assign p2_y = out_y[1];
  assign p3_y = out_y[2];

`ifdef TRI_SCENE_ANIM_EN
  localparam logic signed [12:0] XLO = 13'(X_MIN);
  localparam logic signed [12:0] XHI = 13'(X_MAX);
  localparam logic signed [12:0] YLO = 13'(Y_MIN);
  localparam logic signed [12:0] YHI = 13'(Y_MAX);

  logic [7:0]         frame_cnt;
  logic               frame_wrap;
  logic signed [2:0]  dx;
  logic signed [1:0]  dy;
  logic signed [12:0] dx_w, dy_w;
  logic signed [12:0] sx, sy;
  logic               x_ok, y_ok;

  assign frame_wrap = (state == IDLE) && frame_start && (frame_cnt == 8'(ANIM_DIV - 1));
  assign dx_w = 13'(dx);
  assign dy_w = 13'(dy);

  // An axis moves only if all three vertices stay inside after the step.
  always_comb begin
    x_ok = 1'b1;
    y_ok = 1'b1;
    sx   = '0;
    sy   = '0;
    for (int v = 0; v < 3; v++) begin
      sx = $signed({2'b00, sh_x[v]}) + dx_w;
      sy = $signed({3'b000, sh_y[v]}) + dy_w;
      if (sx < XLO || sx > XHI) x_ok = 1'b0;
      if (sy < YLO || sy > YHI) y_ok = 1'b0;
    end
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_load) state_nx = LOAD;
`ifdef TRI_SCENE_ANIM_EN
        else if (frame_wrap) state_nx = MOVE;
`endif
      end
      LOAD:    if (load_cnt == 3'd5) state_nx = PEND;
`ifdef TRI_SCENE_ANIM_EN
      MOVE:    state_nx = PEND;
`endif
      PEND:    if (frame_start) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      btn_q      <= 1'b0;
      req        <= 1'b0;
      load_cnt   <= 3'd0;
      preset_idx <= 2'd0;
      for (int v = 0; v < 3; v++) begin
        sh_x[v]  <= PRESET[0][(5 - 2 * v) * 11 +: 11];
        sh_y[v]  <= PRESET[0][(4 - 2 * v) * 11 +: 10];
        out_x[v] <= PRESET[0][(5 - 2 * v) * 11 +: 11];
        out_y[v] <= PRESET[0][(4 - 2 * v) * 11 +: 10];
      end
`ifdef TRI_SCENE_ANIM_EN
      frame_cnt <= 8'd0;
      dx        <= 3'sd2;
      dy        <= 2'sd1;
`endif
    end else begin
      btn_q <= btn_next;
      if (start_load) begin
        req        <= 1'b0;
        preset_idx <= preset_idx + 2'd1;
        load_cnt   <= 3'd0;
`ifdef TRI_SCENE_ANIM_EN
        dx <= 3'sd2;
        dy <= 2'sd1;
`endif
      end else if (btn_edge && busy) begin
        req <= 1'b1;
      end

`ifdef TRI_SCENE_ANIM_EN
      // A load taking the IDLE cycle swallows that frame_start entirely.
      if (state == IDLE && frame_start && !start_load)
        frame_cnt <= frame_wrap ? 8'd0 : frame_cnt + 8'd1;

      if (state == MOVE) begin
        if (x_ok) begin
          for (int v = 0; v < 3; v++) sh_x[v] <= 11'($signed({2'b00, sh_x[v]}) + dx_w);
        end else begin
          dx <= -dx;
        end
        if (y_ok) begin
          for (int v = 0; v < 3; v++) sh_y[v] <= 10'($signed({3'b000, sh_y[v]}) + dy_w);
        end else begin
          dy <= -dy;
        end
      end
`endif

      if (state == LOAD) begin
        load_cnt <= load_cnt + 3'd1;
        case (load_cnt)
          3'd0:    sh_x[0] <= load_val;
          3'd1:    sh_y[0] <= load_val[9:0];
          3'd2:    sh_x[1] <= load_val;
          3'd3:    sh_y[1] <= load_val[9:0];
          3'd4:    sh_x[2] <= load_val;
          3'd5:    sh_y[2] <= load_val[9:0];
          default: ;
        endcase
      end

      if (state == COMMIT) begin
        for (int v = 0; v < 3; v++) begin
          out_x[v] <= sh_x[v];
          out_y[v] <= sh_y[v];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_triangle_scene_ctrl.sv
`default_nettype none
// Self-checking bench for triangle_scene_ctrl: directed sequences, a press table
// and a randomized run against a transaction-level reference model.
module tb_triangle_scene_ctrl;

`ifdef TRI_SCENE_ANIM_EN
  localparam int ADIV = 1;
`else
  localparam int ADIV = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        btn_next = 1'b0;
  logic [10:0] p1_x, p2_x, p3_x;
  logic [9:0]  p1_y, p2_y, p3_y;
  logic [1:0]  preset_idx;
  logic        busy;
  logic [62:0] outs;

  triangle_scene_ctrl #(.ANIM_DIV(ADIV)) dut (
    .CLOCK_50(clk), .rst(rst), .frame_start(frame_start), .btn_next(btn_next),
    .p1_x(p1_x), .p2_x(p2_x), .p3_x(p3_x),
    .p1_y(p1_y), .p2_y(p2_y), .p3_y(p3_y),
    .preset_idx(preset_idx), .busy(busy)
  );

  always #5 clk = ~clk;
  assign outs = {p1_x, p1_y, p2_x, p2_y, p3_x, p3_y};

  int n_cmp  = 0;
  int n_fail = 0;
  int px [4][3] = '{'{300, 400, 600}, '{700, 500, 900}, '{400, 800, 1200}, '{1000, 1400, 1200}};
  int py [4][3] = '{'{100, 300, 200}, '{50, 400, 400}, '{200, 100, 450}, '{60, 60, 480}};

  typedef struct { int delay; int exp_idx; } press_t;
  press_t tbl [4];

  // Reference model state: committed picture, index, and remaining busy phases.
  int   m_idx, m_out, m_load_left;
  bit   m_pend, m_commit, m_req, m_btn_prev;

  function automatic logic [62:0] pk(input int k);
    return {11'(px[k][0]), 10'(py[k][0]), 11'(px[k][1]), 10'(py[k][1]),
            11'(px[k][2]), 10'(py[k][2])};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
  endtask

  task automatic commit();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic model_step(input bit b, input bit fs);
    bit e;
    e = b && !m_btn_prev;
    m_btn_prev = b;
    if (m_commit) begin
      m_out = m_idx;
      m_commit = 0;
      if (e) m_req = 1;
    end else if (m_load_left > 0) begin
      m_load_left--;
      if (m_load_left == 0) m_pend = 1;
      if (e) m_req = 1;
    end else if (m_pend) begin
      if (fs) begin m_pend = 0; m_commit = 1; end
      if (e) m_req = 1;
    end else if (e || m_req) begin
      m_idx = (m_idx + 1) % 4;
      m_req = 0;
      m_load_left = 6;
    end
  endtask

  initial begin
    tbl[0] = '{6, 1};
    tbl[1] = '{9, 2};
    tbl[2] = '{12, 3};
    tbl[3] = '{7, 0};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_outs", outs, pk(0));
    check("reset_idx", preset_idx, 0);
    check("reset_busy", busy, 0);

    // Single press, commit 20 cycles after the edge is taken.
    press();
    for (int i = 0; i < 20; i++) check("busy_hold", busy, 1);
    for (int i = 0; i < 20; i++) if (i > 0) tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("commit_cycle_outs_old", outs, pk(0));
    check("commit_cycle_busy", busy, 1);
    tick();
    check("p1_outs", outs, pk(1));
    check("p1_idx", preset_idx, 1);
    check("p1_busy", busy, 0);

    // frame_start during LOAD must not commit.
    press();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (8) tick();
    check("fs_in_load_busy", busy, 1);
    check("fs_in_load_outs", outs, pk(1));
    commit();
    check("p2_outs", outs, pk(2));
    check("p2_idx", preset_idx, 2);

    // Reset on the third LOAD cycle.
    press();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_load_outs", outs, pk(0));
    check("rst_load_idx", preset_idx, 0);
    check("rst_load_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Four presses walk the presets 1,2,3,0.
    for (int r = 0; r < 4; r++) begin
      press();
      repeat (tbl[r].delay) tick();
      commit();
      check("tbl_idx", preset_idx, tbl[r].exp_idx);
      check("tbl_outs", outs, pk(tbl[r].exp_idx));
      check("tbl_busy", busy, 0);
    end

    // Three edges during one LOAD collapse into one extra load.
    press();
    for (int i = 0; i < 3; i++) begin
      tick();
      btn_next = 1'b1;
      tick();
      btn_next = 1'b0;
    end
    commit();
    check("req_first_outs", outs, pk(1));
    tick();
    check("req_reload_busy", busy, 1);
    check("req_reload_idx", preset_idx, 2);
    repeat (6) tick();
    commit();
    check("req_final_outs", outs, pk(2));
    check("req_final_idx", preset_idx, 2);
    repeat (10) tick();
    check("req_no_third", busy, 0);

`ifndef TRI_SCENE_ANIM_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_idx = 0; m_out = 0; m_load_left = 0;
    m_pend = 0; m_commit = 0; m_req = 0; m_btn_prev = 0;
    for (int c = 0; c < 1500; c++) begin
      btn_next    = ($urandom_range(0, 9) == 0);
      frame_start = ($urandom_range(0, 7) == 0);
      model_step(btn_next, frame_start);
      tick();
      check("rnd_busy", busy, (m_load_left > 0 || m_pend || m_commit) ? 1 : 0);
      check("rnd_idx", preset_idx, m_idx);
      check("rnd_outs", outs, pk(m_out));
    end
    btn_next = 1'b0;
    frame_start = 1'b0;
`else
    begin
      bit saw_top, reversed;
      saw_top = 0;
      reversed = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        press();
        repeat (6) tick();
        commit();
      end
      check("anim_start", outs, pk(3));
      for (int f = 1; f <= 160; f++) begin
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) tick();
        if (f == 2) begin
          check("anim_first_y", p3_y, 481);
          check("anim_first_x", p3_x, 1202);
        end
        check("anim_y_bounds", (p1_y >= 35 && p2_y >= 35 && p3_y >= 35 &&
                                p1_y <= 514 && p2_y <= 514 && p3_y <= 514), 1);
        check("anim_x_bounds", (p1_x >= 285 && p2_x >= 285 && p3_x >= 285 &&
                                p1_x <= 1554 && p2_x <= 1554 && p3_x <= 1554), 1);
        if (p3_y == 514) saw_top = 1;
        if (saw_top && p3_y < 514) reversed = 1;
      end
      check("anim_reached_514", saw_top, 1);
      check("anim_reversed", reversed, 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
